// File: rtl/if_id_skid_pkg.sv
// rtl/if_id_skid_pkg.sv - shared IF/ID widths, state encodings, bubble encoding and CLEAR macro
`ifndef CLEAR
`define CLEAR(w) {(w){1'b0}}
`endif

package if_id_skid_pkg;

    localparam int          DEFAULT_PC_SIZE             = 32;
    localparam int          DEFAULT_ID_INSTRUCTION_SIZE = 32;
    localparam logic [31:0] DEFAULT_NOP_INSTRUCTION     = 32'h0000_0000;

    // State value doubles as the occupancy count.
    typedef enum logic [1:0] {
        IF_ID_EMPTY = 2'd0,
        IF_ID_ONE   = 2'd1,
        IF_ID_TWO   = 2'd2
    } if_id_state_t;

endpackage

// File: rtl/if_id_entry.sv
// rtl/if_id_entry.sv - PC + instruction register pair with load enable
module if_id_entry
    import if_id_skid_pkg::*;
#(
    parameter int                          PC_SIZE           = DEFAULT_PC_SIZE,
    parameter int                          INSTRUCTION_SIZE  = DEFAULT_ID_INSTRUCTION_SIZE,
    parameter logic [INSTRUCTION_SIZE-1:0] RESET_INSTRUCTION = DEFAULT_NOP_INSTRUCTION
) (
    input  logic                        i_clk,
    input  logic                        i_reset,
    input  logic                        i_load,
    input  logic [PC_SIZE-1:0]          i_next_seq_pc,
    input  logic [INSTRUCTION_SIZE-1:0] i_instruction,
    output logic [PC_SIZE-1:0]          o_next_seq_pc,
    output logic [INSTRUCTION_SIZE-1:0] o_instruction
);

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            o_next_seq_pc <= `CLEAR(PC_SIZE);
            o_instruction <= RESET_INSTRUCTION;
        end else if (i_load) begin
            o_next_seq_pc <= i_next_seq_pc;
            o_instruction <= i_instruction;
        end
    end

endmodule

// File: rtl/if_id_skid.sv
// rtl/if_id_skid.sv - IF/ID stage with two-entry skid buffer and flush; option IF_ID_SKID_BUBBLE_NOP_EN
module if_id_skid
    import if_id_skid_pkg::*;
#(
    parameter int                          PC_SIZE          = DEFAULT_PC_SIZE,
    parameter int                          INSTRUCTION_SIZE = DEFAULT_ID_INSTRUCTION_SIZE,
    parameter logic [INSTRUCTION_SIZE-1:0] NOP_INSTRUCTION  = DEFAULT_NOP_INSTRUCTION
) (
    input  logic                        i_clk,
    input  logic                        i_reset,
    input  logic                        i_valid,
    output logic                        o_ready,
    input  logic [PC_SIZE-1:0]          i_next_seq_pc,
    input  logic [INSTRUCTION_SIZE-1:0] i_instruction,
    input  logic                        i_flush,
    output logic                        o_valid,
    input  logic                        i_ready,
    output logic [PC_SIZE-1:0]          o_next_seq_pc,
    output logic [INSTRUCTION_SIZE-1:0] o_instruction,
    output logic [1:0]                  o_occupancy
);

`ifdef IF_ID_SKID_BUBBLE_NOP_EN
    localparam bit BUBBLE_NOP_EN = 1'b1;
`else
    localparam bit BUBBLE_NOP_EN = 1'b0;
`endif

    if_id_state_t state, state_next;
    logic         ready_q;
    logic         accept, drain;
    logic         main_load, main_from_skid, main_clear, skid_load;
    logic         main_we;

    logic [PC_SIZE-1:0]          skid_pc,    main_pc_d;
    logic [INSTRUCTION_SIZE-1:0] skid_instr, main_instr_d;

    assign accept = i_valid & ready_q;
    assign drain  = o_valid & i_ready;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state   <= IF_ID_EMPTY;
            ready_q <= 1'b1;
        end else begin
            state   <= state_next;
            ready_q <= (state_next != IF_ID_TWO);
        end
    end

    always_comb begin
        state_next     = state;
        main_load      = 1'b0;
        main_from_skid = 1'b0;
        main_clear     = 1'b0;
        skid_load      = 1'b0;
        case (state)
            IF_ID_EMPTY: begin
                if (accept) begin
                    state_next = IF_ID_ONE;
                    main_load  = 1'b1;
                end
            end
            IF_ID_ONE: begin
                if (accept && drain) begin
                    main_load = 1'b1;
                end else if (accept) begin
                    state_next = IF_ID_TWO;
                    skid_load  = 1'b1;
                end else if (drain) begin
                    state_next = IF_ID_EMPTY;
                    main_clear = 1'b1;
                end
            end
            IF_ID_TWO: begin
                if (drain) begin
                    state_next     = IF_ID_ONE;
                    main_load      = 1'b1;
                    main_from_skid = 1'b1;
                end
            end
            default: state_next = IF_ID_EMPTY;
        endcase
        // Redirect: everything held or arriving this cycle is discarded.
        if (i_flush) begin
            state_next     = IF_ID_EMPTY;
            main_load      = 1'b0;
            main_from_skid = 1'b0;
            skid_load      = 1'b0;
            main_clear     = 1'b1;
        end
    end

    // With bubble-NOP enabled the main register is scrubbed whenever it goes empty.
    assign main_we      = main_load | (BUBBLE_NOP_EN & main_clear);
    assign main_pc_d    = (BUBBLE_NOP_EN && main_clear) ? `CLEAR(PC_SIZE)
                        : main_from_skid ? skid_pc : i_next_seq_pc;
    assign main_instr_d = (BUBBLE_NOP_EN && main_clear) ? NOP_INSTRUCTION
                        : main_from_skid ? skid_instr : i_instruction;

    if_id_entry #(
        .PC_SIZE          (PC_SIZE),
        .INSTRUCTION_SIZE (INSTRUCTION_SIZE),
        .RESET_INSTRUCTION(NOP_INSTRUCTION)
    ) u_main (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_load        (main_we),
        .i_next_seq_pc (main_pc_d),
        .i_instruction (main_instr_d),
        .o_next_seq_pc (o_next_seq_pc),
        .o_instruction (o_instruction)
    );

    if_id_entry #(
        .PC_SIZE          (PC_SIZE),
        .INSTRUCTION_SIZE (INSTRUCTION_SIZE),
        .RESET_INSTRUCTION(NOP_INSTRUCTION)
    ) u_skid (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_load        (skid_load),
        .i_next_seq_pc (i_next_seq_pc),
        .i_instruction (i_instruction),
        .o_next_seq_pc (skid_pc),
        .o_instruction (skid_instr)
    );

    assign o_valid     = (state != IF_ID_EMPTY);
    assign o_ready     = ready_q;
    assign o_occupancy = state;

endmodule

// File: tb/tb_if_id_skid.sv
// tb/tb_if_id_skid.sv - directed and scoreboarded checks for if_id_skid
module tb_if_id_skid;

    localparam logic [31:0] NOP = 32'h0000_0000;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_valid;
    logic        o_ready;
    logic [31:0] i_next_seq_pc;
    logic [31:0] i_instruction;
    logic        i_flush;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_next_seq_pc;
    logic [31:0] o_instruction;
    logic [1:0]  o_occupancy;

    int total = 0;
    int bad   = 0;

    if_id_skid #(
        .PC_SIZE         (32),
        .INSTRUCTION_SIZE(32),
        .NOP_INSTRUCTION (NOP)
    ) dut (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_valid       (i_valid),
        .o_ready       (o_ready),
        .i_next_seq_pc (i_next_seq_pc),
        .i_instruction (i_instruction),
        .i_flush       (i_flush),
        .o_valid       (o_valid),
        .i_ready       (i_ready),
        .o_next_seq_pc (o_next_seq_pc),
        .o_instruction (o_instruction),
        .o_occupancy   (o_occupancy)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins);
        i_valid       = v;
        i_next_seq_pc = pc;
        i_instruction = ins;
    endtask

    logic [63:0] sb[$];
    logic        acc, drn;
    logic [31:0] k;

    initial begin
        i_reset = 1'b1;
        i_flush = 1'b0;
        i_ready = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        #2 i_reset = 1'b0;
        #1;
        chk("rst_valid", o_valid, 0);
        chk("rst_ready", o_ready, 1);
        chk("rst_occ",   o_occupancy, 0);
        chk("rst_instr", o_instruction, NOP);
        chk("rst_pc",    o_next_seq_pc, 0);
        tick();
        i_reset = 1'b1;

        // streaming at full rate
        i_ready = 1'b1;
        drive(1'b1, 32'd4, 32'h11);
        tick();
        chk("str1_instr", o_instruction, 32'h11);
        chk("str1_pc",    o_next_seq_pc, 32'd4);
        chk("str1_occ",   o_occupancy, 1);
        drive(1'b1, 32'd8, 32'h22);
        tick();
        chk("str2_instr", o_instruction, 32'h22);
        chk("str2_pc",    o_next_seq_pc, 32'd8);
        chk("str2_occ",   o_occupancy, 1);
        chk("str2_ready", o_ready, 1);
        drive(1'b1, 32'd12, 32'h33);
        tick();
        chk("str3_instr", o_instruction, 32'h33);
        chk("str3_pc",    o_next_seq_pc, 32'd12);
        chk("str3_occ",   o_occupancy, 1);
        drive(1'b0, 32'd0, 32'h0);
        tick();
        chk("str_empty_valid", o_valid, 0);
        chk("str_empty_occ",   o_occupancy, 0);

        // skid under three stalled cycles
        i_ready = 1'b0;
        drive(1'b1, 32'h100, 32'hA1);
        tick();
        chk("skid1_occ",   o_occupancy, 1);
        chk("skid1_ready", o_ready, 1);
        drive(1'b1, 32'h104, 32'hA2);
        tick();
        chk("skid2_occ",   o_occupancy, 2);
        chk("skid2_ready", o_ready, 0);
        chk("skid2_instr", o_instruction, 32'hA1);
        drive(1'b1, 32'h108, 32'hA3);
        tick();
        chk("skid3_occ",   o_occupancy, 2);
        chk("skid3_ready", o_ready, 0);
        chk("skid3_instr", o_instruction, 32'hA1);
        i_ready = 1'b1;
        tick();
        chk("skid4_instr", o_instruction, 32'hA2);
        chk("skid4_pc",    o_next_seq_pc, 32'h104);
        chk("skid4_occ",   o_occupancy, 1);
        chk("skid4_ready", o_ready, 1);
        tick();
        chk("skid5_instr", o_instruction, 32'hA3);
        chk("skid5_occ",   o_occupancy, 1);
        drive(1'b0, 32'h0, 32'h0);
        tick();
        chk("skid6_occ", o_occupancy, 0);

        // flush with full buffer and an incoming entry
        i_ready = 1'b0;
        drive(1'b1, 32'h200, 32'hC1);
        tick();
        drive(1'b1, 32'h204, 32'hC2);
        tick();
        chk("fl_pre_occ", o_occupancy, 2);
        i_ready = 1'b1;
        i_flush = 1'b1;
        drive(1'b1, 32'h208, 32'hB0);
        tick();
        chk("fl_valid", o_valid, 0);
        chk("fl_occ",   o_occupancy, 0);
        chk("fl_ready", o_ready, 1);
        i_flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        tick();
        chk("fl_post_valid", o_valid, 0);
        chk("fl_post_occ",   o_occupancy, 0);

        // asynchronous reset with two entries held
        i_ready = 1'b0;
        drive(1'b1, 32'h300, 32'hD1);
        tick();
        drive(1'b1, 32'h304, 32'hD2);
        tick();
        chk("ar_pre_occ", o_occupancy, 2);
        i_reset = 1'b0;
        #1;
        chk("ar_valid", o_valid, 0);
        chk("ar_ready", o_ready, 1);
        chk("ar_occ",   o_occupancy, 0);
        chk("ar_instr", o_instruction, NOP);
        i_reset = 1'b1;
        drive(1'b1, 32'h400, 32'hE1);
        tick();
        chk("ar_first_valid", o_valid, 1);
        chk("ar_first_instr", o_instruction, 32'hE1);
        drive(1'b0, 32'h0, 32'h0);
        i_ready = 1'b1;
        tick();
        chk("ar_drained_occ", o_occupancy, 0);

        // random accept/drain against a FIFO scoreboard
        k = 32'd0;
        for (int c = 0; c < 1000; c++) begin
            drive(1'($urandom_range(0, 1)), k << 2, 32'h1000_0000 + k);
            i_ready = 1'($urandom_range(0, 1));
            acc = i_valid & o_ready;
            drn = o_valid & i_ready;
            chk("rnd_ready", o_ready, (o_occupancy != 2'd2));
            chk("rnd_occ",   o_occupancy, sb.size());
            if (drn) begin
                if (sb.size() == 0) begin
                    chk("rnd_underflow", 1, 0);
                end else begin
                    chk("rnd_data", {o_next_seq_pc, o_instruction}, sb[0]);
                    void'(sb.pop_front());
                end
            end
            if (acc) begin
                sb.push_back({i_next_seq_pc, i_instruction});
                k = k + 1;
            end
            tick();
        end

        // drain to empty
        drive(1'b0, 32'h0, 32'h0);
        i_ready = 1'b1;
        tick();
        tick();
        chk("end_valid", o_valid, 0);
        chk("end_occ",   o_occupancy, 0);
`ifdef IF_ID_SKID_BUBBLE_NOP_EN
        chk("bubble_instr", o_instruction, NOP);
        chk("bubble_pc",    o_next_seq_pc, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
